uart_rx: RTL and testbench

UART receiver paired with the team's UART transmitter on the Basys3 USB-UART link. It receives 8N1 frames on the serial input RsRx: start bit low, 8 data bits LSB first, no parity, stop bit high. Each bit is sampled at its midpoint using a CLKS_PER_BIT timebase. A received byte is presented with a one-cycle valid strobe, and bad frames are flagged with a framing-error strobe.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bundle: the raw RsRx line in, the received byte and status strobes out.
// The receiver takes the slave view; whatever drives the line takes the master view.
interface uart_rx_if;
    logic       RsRx;
    logic [7:0] outputdata;
    logic       dataValid;
    logic       active;
    logic       frameErr;

    modport master (
        output RsRx,
        input  outputdata,
        input  dataValid,
        input  active,
        input  frameErr
    );

    modport slave (
        input  RsRx,
        output outputdata,
        output dataValid,
        output active,
        output frameErr
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a two-flop line synchronizer,
// a one-cycle byte strobe and a one-cycle framing-error strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int          HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_CLEAN = 3'd4;

    logic [1:0]  sync_reg;
    logic        rx_s;
    logic [2:0]  state_reg, state_next;
    logic [15:0] counter_reg, counter_next;
    logic [2:0]  index_reg, index_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  out_reg, out_next;
    logic        valid_reg, valid_next;
    logic        ferr_reg, ferr_next;
    logic        active_reg, active_next;
    logic        bit_sample;
    logic        half_hit;
    logic        bit_hit;

    assign rx_s     = sync_reg[1];
    assign half_hit = (counter_reg == HALF_CNT);
    assign bit_hit  = (counter_reg == BIT_END);

    // Each shift bit only loads when its own index is being sampled.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (bit_sample && index_reg == 3'(gi)) ? rx_s : shift_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg + 16'd1;
        index_next   = index_reg;
        out_next     = out_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        active_next  = active_reg;
        bit_sample   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                counter_next = 16'd0;
                active_next  = 1'b0;
                if (!rx_s) begin
                    state_next  = ST_START;
                    active_next = 1'b1;
                end
            end
            ST_START: begin
                if (half_hit) begin
                    counter_next = 16'd0;
                    if (!rx_s) begin
                        state_next = ST_DATA;
                        index_next = 3'd0;
                    end else begin
                        state_next  = ST_IDLE;
                        active_next = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (bit_hit) begin
                    counter_next = 16'd0;
                    bit_sample   = 1'b1;
                    if (index_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        index_next = index_reg + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_hit) begin
                    counter_next = 16'd0;
                    active_next  = 1'b0;
                    state_next   = ST_CLEAN;
                    if (rx_s) begin
                        valid_next = 1'b1;
                        out_next   = shift_reg;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end
            end
            ST_CLEAN: begin
                // A held-low break parks here until the line recovers.
                counter_next = 16'd0;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                counter_next = 16'd0;
                active_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg    <= 2'b11;
            state_reg   <= ST_IDLE;
            counter_reg <= 16'd0;
            index_reg   <= 3'd0;
            shift_reg   <= 8'h00;
            out_reg     <= 8'h00;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            active_reg  <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], bus.RsRx};
            state_reg   <= state_next;
            counter_reg <= counter_next;
            index_reg   <= index_next;
            shift_reg   <= shift_next;
            out_reg     <= out_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
            active_reg  <= active_next;
        end
    end

    assign bus.outputdata = out_reg;
    assign bus.dataValid  = valid_reg;
    assign bus.frameErr   = ferr_reg;
    assign bus.active     = active_reg;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame-level expectation queue predicts every strobe, its
// byte and its arrival window; one negedge process compares the DUT against it.
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 2 + (HALF + 1) + 9 * CPB;

    typedef struct {
        logic [7:0] data;
        bit         err;
        int         t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t       q[$];
    logic [7:0] last_byte = 8'h00;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         armed = 1'b0;
    int         last_valid_cyc = -1;
    int         prev_valid_cyc = -1;
    int         n_valid = 0;
    int         n_ferr = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at cycle %0d", nm, act, req, cyc);
        end
    endfunction

    // Per-cycle comparison against the frame-level model.
    exp_t e;
    int   lat;
    int   d;
    always @(negedge clk) begin
        if (armed) begin
            chk("strobes_exclusive", 32'(bus.dataValid && bus.frameErr), 32'd0);
            if (bus.dataValid || bus.frameErr) begin
                if (q.size() == 0) begin
                    chk("spurious_strobe", 32'(bus.dataValid || bus.frameErr), 32'd0);
                end else begin
                    e   = q.pop_front();
                    lat = cyc - e.t0;
                    chk("strobe_kind_ferr", 32'(bus.frameErr), 32'(e.err));
                    chk("latency_in_window", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
                    if (!e.err) last_byte = e.data;
                end
                if (bus.dataValid) begin
                    n_valid++;
                    prev_valid_cyc = last_valid_cyc;
                    last_valid_cyc = cyc;
                end
                if (bus.frameErr) n_ferr++;
            end else if (q.size() > 0 && cyc - q[0].t0 > LAT + 1) begin
                chk("strobe_missing", 32'(bus.dataValid || bus.frameErr), 32'd1);
                e = q.pop_front();
            end
            chk("outputdata", 32'(bus.outputdata), 32'(last_byte));
            if (q.size() > 0) begin
                d = cyc - q[0].t0;
                if (d >= 4 && d <= LAT - 1) chk("active_in_frame", 32'(bus.active), 32'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line_high(input int n);
        bus.RsRx = 1'b1;
        tick(n);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.RsRx = 1'b1;
        tick(1);
        q.delete();
        last_byte = 8'h00;
        chk("rst_outputdata", 32'(bus.outputdata), 32'd0);
        chk("rst_dataValid",  32'(bus.dataValid),  32'd0);
        chk("rst_active",     32'(bus.active),     32'd0);
        chk("rst_frameErr",   32'(bus.frameErr),   32'd0);
        rst = 1'b0;
    endtask

    // abort_bit >= 0 pulses reset halfway through that data bit.
    task automatic send_frame(input logic [7:0] dat, input bit stop_ok, input int abort_bit);
        exp_t x;
        bus.RsRx = 1'b0;
        x.data = dat;
        x.err  = !stop_ok;
        x.t0   = cyc;
        q.push_back(x);
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.RsRx = dat[i];
            if (i == abort_bit) begin
                tick(CPB / 2);
                do_reset();
                return;
            end
            tick(CPB);
        end
        bus.RsRx = stop_ok;
        tick(CPB);
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 40 && q.size() > 0; i++) tick(1);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, nv, nf, r, glen;
        bit err;
        bus.RsRx = 1'b1;
        rst = 1'b1;
        tick(3);
        chk("reset_outputdata", 32'(bus.outputdata), 32'd0);
        chk("reset_dataValid",  32'(bus.dataValid),  32'd0);
        chk("reset_active",     32'(bus.active),     32'd0);
        chk("reset_frameErr",   32'(bus.frameErr),   32'd0);
        rst = 1'b0;
        armed = 1'b1;
        line_high(5);

        // Single 0xA5 frame
        t1 = cyc;
        nv = n_valid;
        send_frame(8'hA5, 1'b1, -1);
        line_high(10);
        drain();
        chk("t1_one_pulse", 32'(n_valid - nv), 32'd1);
        chk("t1_latency_153_155", 32'(last_valid_cyc - t1 >= 153 && last_valid_cyc - t1 <= 155), 32'd1);
        chk("t1_byte", 32'(bus.outputdata), 32'hA5);

        // Back-to-back 0x00 then 0xFF
        nv = n_valid;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        line_high(10);
        drain();
        chk("t2_two_pulses", 32'(n_valid - nv), 32'd2);
        chk("t2_spacing_159_161",
            32'(last_valid_cyc - prev_valid_cyc >= 159 && last_valid_cyc - prev_valid_cyc <= 161), 32'd1);
        chk("t2_byte", 32'(bus.outputdata), 32'hFF);

        // Short glitch is rejected
        nv = n_valid;
        nf = n_ferr;
        bus.RsRx = 1'b0;
        tick(4);
        line_high(30);
        chk("t3_no_valid", 32'(n_valid - nv), 32'd0);
        chk("t3_no_ferr", 32'(n_ferr - nf), 32'd0);
        chk("t3_byte_kept", 32'(bus.outputdata), 32'hFF);

        // Bad stop bit, break, then recovery
        nv = n_valid;
        nf = n_ferr;
        send_frame(8'h3C, 1'b0, -1);
        bus.RsRx = 1'b0;
        tick(50);
        line_high(20);
        drain();
        chk("t4_one_ferr", 32'(n_ferr - nf), 32'd1);
        chk("t4_no_valid", 32'(n_valid - nv), 32'd0);
        chk("t4_byte_kept", 32'(bus.outputdata), 32'hFF);
        send_frame(8'h3C, 1'b1, -1);
        line_high(10);
        drain();
        chk("t4_recovered_byte", 32'(bus.outputdata), 32'h3C);

        // Reset during data bit 3, then a fresh frame
        send_frame(8'h81, 1'b1, 3);
        line_high(20);
        chk("t5_after_reset", 32'(bus.outputdata), 32'h00);
        send_frame(8'h81, 1'b1, -1);
        line_high(10);
        drain();
        chk("t5_byte", 32'(bus.outputdata), 32'h81);

        // Continuous stream of every byte value
        nv = n_valid;
        nf = n_ferr;
        for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, -1);
        line_high(10);
        drain();
        chk("t6_pulses", 32'(n_valid - nv), 32'd256);
        chk("t6_no_ferr", 32'(n_ferr - nf), 32'd0);
        chk("t6_last_byte", 32'(bus.outputdata), 32'hFF);

        // Randomized frames, framing errors, glitches and gaps
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
                glen = $urandom_range(1, 5);
                bus.RsRx = 1'b0;
                tick(glen);
                line_high(20);
            end else begin
                err = (r == 1);
                send_frame(8'($urandom), !err, -1);
                if (err) begin
                    bus.RsRx = 1'b0;
                    tick($urandom_range(0, 30));
                    line_high(CPB + $urandom_range(0, 10));
                end else begin
                    line_high($urandom_range(0, 20));
                end
            end
        end
        line_high(10);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
